// File: rtl/uart_pkg.sv
// Shared constants for the parametrised UART blocks: parity modes,
// receiver FSM encoding and the oversample divider calculation.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP1  = 3'd4;
  localparam logic [2:0] ST_STOP2  = 3'd5;

  // Rounded clocks per oversample tick.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: counts 0..DIV-1 and flags the last count.
// A synchronous clear realigns the tick phase to an external event.
module uart_baud_gen #(
  parameter int DIV = 430
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == CW'(DIV - 1))) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority-vote sampling, false-start
// rejection, error flags and a one-word valid/ready holding register.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 66_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] parallel_out,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy,
  output logic                 baudrate_clk
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int H   = OVERSAMPLE / 2;
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);

  logic                 r_sync1, r_sync2, r_lineHigh;
  logic [1:0]           r_fill;
  logic [2:0]           r_state;
  logic [SCW-1:0]       r_sampleCnt;
  logic [BCW-1:0]       r_bitCnt;
  logic                 r_samp0, r_samp1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parErr, r_parBit, r_frameErr, r_stopLow;

  logic w_fall, w_clear, w_tick, w_maj, w_decide, w_bitEnd, w_parExpect;
  logic w_done, w_finalFrameErr, w_finalStopLow, w_break;

  uart_baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  assign baudrate_clk = w_tick;

  // r_lineHigh only learns from real line samples, so a line held low
  // through reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_fill     <= 2'b00;
      r_lineHigh <= 1'b0;
    end else begin
      r_sync1    <= serial_in;
      r_sync2    <= r_sync1;
      r_fill     <= {r_fill[0], 1'b1};
      r_lineHigh <= r_fill[1] & r_sync2;
    end
  end

  assign w_fall      = r_lineHigh & ~r_sync2;
  assign w_clear     = (r_state == ST_IDLE) && w_fall;
  assign w_maj       = (r_samp0 & r_samp1) | (r_samp0 & r_sync2) | (r_samp1 & r_sync2);
  assign w_decide    = w_tick && (r_sampleCnt == SCW'(H + 1));
  assign w_bitEnd    = w_tick && (r_sampleCnt == SCW'(OVERSAMPLE - 1));
  assign w_parExpect = (PARITY == PARITY_ODD) ? ~^r_shift : ^r_shift;

  assign w_done = w_decide &&
                  (((r_state == ST_STOP1) && (STOP_BITS == 1)) || (r_state == ST_STOP2));
  assign w_finalFrameErr = (r_state == ST_STOP2) ? (r_frameErr | ~w_maj) : ~w_maj;
  assign w_finalStopLow  = (r_state == ST_STOP2) ? r_stopLow : ~w_maj;
  assign w_break = (r_shift == '0) && w_finalStopLow &&
                   ((PARITY == PARITY_NONE) || !r_parBit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_sampleCnt <= '0;
      r_bitCnt    <= '0;
      r_samp0     <= 1'b0;
      r_samp1     <= 1'b0;
      r_shift     <= '0;
      r_parErr    <= 1'b0;
      r_parBit    <= 1'b0;
      r_frameErr  <= 1'b0;
      r_stopLow   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (w_tick) begin
        r_sampleCnt <= w_bitEnd ? '0 : r_sampleCnt + 1'b1;
        if (r_sampleCnt == SCW'(H - 1)) r_samp0 <= r_sync2;
        if (r_sampleCnt == SCW'(H))     r_samp1 <= r_sync2;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state     <= ST_START;
            r_sampleCnt <= '0;
            r_bitCnt    <= '0;
            r_parErr    <= 1'b0;
            r_parBit    <= 1'b0;
            r_frameErr  <= 1'b0;
            r_stopLow   <= 1'b0;
            busy        <= 1'b1;
          end
        end
        ST_START: begin
          if (w_decide && w_maj) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else if (w_bitEnd) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_decide) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          if (w_bitEnd) begin
            if (r_bitCnt == BCW'(DATA_BITS - 1)) begin
              r_bitCnt <= '0;
              r_state  <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP1;
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_decide) begin
            r_parErr <= (w_maj != w_parExpect);
            r_parBit <= w_maj;
          end
          if (w_bitEnd) r_state <= ST_STOP1;
        end
        ST_STOP1: begin
          // Leave at the decision point so a start edge half a bit later is caught.
          if (w_decide) begin
            r_frameErr <= ~w_maj;
            r_stopLow  <= ~w_maj;
            if (STOP_BITS == 1) begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end
          end else if (w_bitEnd) begin
            r_state <= ST_STOP2;
          end
        end
        ST_STOP2: begin
          if (w_decide) begin
            r_frameErr <= r_frameErr | ~w_maj;
            r_state    <= ST_IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // A completing frame loads only if the holder is empty or being drained this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parallel_out <= '0;
      rx_valid     <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (w_done) begin
        if (!rx_valid || rx_ready) begin
          parallel_out <= r_shift;
          parity_err   <= r_parErr;
          frame_err    <= w_finalFrameErr;
          break_det    <= w_break;
          rx_valid     <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 receiver and an 8E2 receiver,
// each scaled to 64 clocks per bit so the run stays short.
module tb_uart_rx_param;

  localparam int CLK_FREQ = 6_400_000;
  localparam int BAUD     = 100_000;
  localparam int OS       = 16;
  localparam int BIT_CLKS = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic lineA = 1'b1, lineB = 1'b1;
  logic readyA = 1'b1, readyB = 1'b1;

  logic [7:0] dataA, dataB;
  logic validA, parA, frameA, breakA, ovrA, busyA, tickA;
  logic validB, parB, frameB, breakB, ovrB, busyB, tickB;

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
    .clk(clk), .rst(rst), .serial_in(lineA), .parallel_out(dataA),
    .rx_valid(validA), .rx_ready(readyA), .parity_err(parA), .frame_err(frameA),
    .break_det(breakA), .overrun(ovrA), .busy(busyA), .baudrate_clk(tickA)
  );

  uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dutB (
    .clk(clk), .rst(rst), .serial_in(lineB), .parallel_out(dataB),
    .rx_valid(validB), .rx_ready(readyB), .parity_err(parB), .frame_err(frameB),
    .break_det(breakB), .overrun(ovrB), .busy(busyB), .baudrate_clk(tickB)
  );

  int checkCount = 0;
  int passCount  = 0;
  int accA = 0, accB = 0, ovrCntA = 0, busyRiseA = 0, tickCntA = 0;
  logic busyPrevA = 1'b0;
  logic [7:0] lastDataA = '0, lastDataB = '0;
  logic [2:0] lastFlagsA = '0;
  logic lastParB = 1'b0, lastFrameB = 1'b0;

  // Records accepted words, overrun pulses, busy rises and ticks away from the active edge.
  always @(negedge clk) begin
    if (validA && readyA) begin
      accA++;
      lastDataA  = dataA;
      lastFlagsA = {parA, frameA, breakA};
    end
    if (ovrA) ovrCntA++;
    if (busyA && !busyPrevA) busyRiseA++;
    busyPrevA = busyA;
    if (tickA) tickCntA++;
    if (validB && readyB) begin
      accB++;
      lastDataB  = dataB;
      lastParB   = parB;
      lastFrameB = frameB;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic driveBit(input int which, input logic b);
    if (which == 0) lineA = b;
    else lineB = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Sends one frame plus two idle bits; the 8E2 line also gets parity and a second stop bit.
  task automatic applyStimulus(input int which, input logic [7:0] data, input logic parBit,
                               input logic stop1, input logic stop2);
    driveBit(which, 1'b0);
    for (int i = 0; i < 8; i++) driveBit(which, data[i]);
    if (which == 1) begin
      driveBit(1, parBit);
      driveBit(1, stop1);
      driveBit(1, stop2);
    end else begin
      driveBit(0, stop1);
    end
    driveBit(which, 1'b1);
    driveBit(which, 1'b1);
  endtask

  int accSnap, ovrSnap, busySnap, tickSnap;
  logic [7:0] resetFrame;

  initial begin
    $display("[TB] start");
    repeat (5) @(negedge clk);
    checkOutput("reset_data",  {24'd0, dataA}, 32'h0);
    checkOutput("reset_valid", {31'd0, validA}, 32'h0);
    checkOutput("reset_busy",  {31'd0, busyA}, 32'h0);
    checkOutput("reset_flags", {28'd0, parA, frameA, breakA, ovrA}, 32'h0);
    checkOutput("reset_tick",  {31'd0, tickA}, 32'h0);
    checkOutput("reset_validB", {31'd0, validB}, 32'h0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    tickSnap = tickCntA;
    repeat (40) @(negedge clk);
    checkOutput("tick_rate", tickCntA - tickSnap, 32'd10);

    accSnap = accA;
    applyStimulus(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    checkOutput("a5_accepts", accA - accSnap, 32'd1);
    checkOutput("a5_data",    {24'd0, lastDataA}, 32'hA5);
    checkOutput("a5_flags",   {29'd0, lastFlagsA}, 32'h0);

    applyStimulus(0, 8'h55, 1'b0, 1'b0, 1'b1);
    checkOutput("frame_data",  {24'd0, lastDataA}, 32'h55);
    checkOutput("frame_flags", {29'd0, lastFlagsA}, 32'b010);

    applyStimulus(0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("break_data",  {24'd0, lastDataA}, 32'h00);
    checkOutput("break_flags", {29'd0, lastFlagsA}, 32'b011);

    accSnap  = accA;
    busySnap = busyRiseA;
    lineA = 1'b0;
    repeat (20) @(negedge clk);
    lineA = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    checkOutput("glitch_busy_rise", busyRiseA - busySnap, 32'd1);
    checkOutput("glitch_busy_now",  {31'd0, busyA}, 32'h0);
    checkOutput("glitch_no_word",   accA - accSnap, 32'd0);

    readyA  = 1'b0;
    ovrSnap = ovrCntA;
    applyStimulus(0, 8'h11, 1'b0, 1'b1, 1'b1);
    applyStimulus(0, 8'h22, 1'b0, 1'b1, 1'b1);
    checkOutput("ovr_pulses", ovrCntA - ovrSnap, 32'd1);
    checkOutput("ovr_data",   {24'd0, dataA}, 32'h11);
    checkOutput("ovr_valid",  {31'd0, validA}, 32'h1);
    readyA = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("ovr_drain", {31'd0, validA}, 32'h0);

    readyA     = 1'b0;
    accSnap    = accA;
    ovrSnap    = ovrCntA;
    resetFrame = 8'h0F;
    driveBit(0, 1'b0);
    for (int i = 0; i < 4; i++) driveBit(0, resetFrame[i]);
    lineA = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("midreset_busy", {31'd0, busyA}, 32'h0);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    lineA = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    applyStimulus(0, 8'h7E, 1'b0, 1'b1, 1'b1);
    checkOutput("midreset_data",  {24'd0, dataA}, 32'h7E);
    checkOutput("midreset_valid", {31'd0, validA}, 32'h1);
    checkOutput("midreset_ovr",   ovrCntA - ovrSnap, 32'd0);
    readyA = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midreset_one_word", accA - accSnap, 32'd1);

    accSnap = accB;
    applyStimulus(1, 8'h3C, 1'b1, 1'b1, 1'b1);
    checkOutput("par_bad_accepts", accB - accSnap, 32'd1);
    checkOutput("par_bad_data",    {24'd0, lastDataB}, 32'h3C);
    checkOutput("par_bad_err",     {31'd0, lastParB}, 32'h1);
    checkOutput("par_bad_frame",   {31'd0, lastFrameB}, 32'h0);

    applyStimulus(1, 8'h3C, 1'b0, 1'b1, 1'b1);
    checkOutput("par_ok_err", {31'd0, lastParB}, 32'h0);

    applyStimulus(1, 8'h3C, 1'b0, 1'b1, 1'b0);
    checkOutput("stop2_frame", {31'd0, lastFrameB}, 32'h1);
    checkOutput("stop2_par",   {31'd0, lastParB}, 32'h0);
    checkOutput("stop2_total", accB - accSnap, 32'd3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
